// File: rtl/div_pkg.sv
// Shared types and arithmetic helpers for the pipelined non-restoring divider.
// Functions work on the widest supported word. Callers sign- or zero-extend into these
// types and truncate the results back to their own WIDTH.
package div_pkg;

  localparam int unsigned DivMaxW    = 64;
  localparam int unsigned DivTagMaxW = 16;

  // Width of the partial remainder: WIDTH+1 magnitude bits plus a sign bit
  function automatic int unsigned div_rem_w(input int unsigned width);
    return width + 2;
  endfunction

  localparam int unsigned DivRemMaxW = div_rem_w(DivMaxW);

  typedef logic signed [DivRemMaxW-1:0] div_rem_t;
  typedef logic        [DivMaxW-1:0]    div_word_t;

  // Sideband that travels with every pipeline slot
  typedef struct packed {
    logic                  valid;
    logic                  is_signed;
    logic                  q_neg;
    logic                  r_neg;
    logic                  dbz;
    logic [DivTagMaxW-1:0] tag;
  } div_sb_t;

  typedef struct packed {
    div_word_t quot;
    div_word_t rem;
  } div_res_t;

  // One non-restoring iteration: shift the next dividend bit in, then add the divisor
  // if the partial remainder is negative, otherwise subtract it.
  function automatic div_rem_t div_nr_step(input div_rem_t p, input logic bit_in,
                                           input div_word_t d);
    div_rem_t s;
    div_rem_t dx;
    s  = {p[DivRemMaxW-2:0], bit_in};
    dx = div_rem_t'({2'b00, d});
    return p[DivRemMaxW-1] ? s + dx : s - dx;
  endfunction

  // Remainder correction followed by sign restore of quotient and remainder
  function automatic div_res_t div_fixup(input div_rem_t p, input div_word_t d,
                                         input div_word_t q, input logic q_neg,
                                         input logic r_neg);
    div_rem_t r;
    div_res_t res;
    r        = p[DivRemMaxW-1] ? p + div_rem_t'({2'b00, d}) : p;
    res.quot = q_neg ? -q : q;
    res.rem  = r_neg ? -r[DivMaxW-1:0] : r[DivMaxW-1:0];
    return res;
  endfunction

endpackage

// File: rtl/div_nr_stage.sv
// One register stage of the divider: ITERS non-restoring iterations on the partial
// remainder. The dividend register shifts left each iteration and collects quotient
// bits in its low end, so after all stages it holds the full quotient.
module div_nr_stage
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITERS = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clken,
  input  div_sb_t                     sb_in,
  input  logic [div_rem_w(WIDTH)-1:0] p_in,
  input  logic [WIDTH-1:0]            d_in,
  input  logic [WIDTH-1:0]            a_in,
  output div_sb_t                     sb_out,
  output logic [div_rem_w(WIDTH)-1:0] p_out,
  output logic [WIDTH-1:0]            d_out,
  output logic [WIDTH-1:0]            a_out
);

  localparam int unsigned RemW = div_rem_w(WIDTH);

  logic [RemW-1:0]  p_v;
  logic [WIDTH-1:0] a_v;
  div_rem_t         p_ext;
  logic             unused_ext;

  // Unrolled iterations for this stage
  always_comb begin
    p_v   = p_in;
    a_v   = a_in;
    p_ext = '0;
    for (int i = 0; i < int'(ITERS); i++) begin
      p_ext = div_nr_step(div_rem_t'(signed'(p_v)), a_v[WIDTH-1], div_word_t'(d_in));
      p_v   = p_ext[RemW-1:0];
      a_v   = {a_v[WIDTH-2:0], ~p_v[RemW-1]};
    end
  end

  // Upper bits of the widened step result are always sign copies
  assign unused_ext = ^p_ext;

  // Stage register; sideband moves in lockstep with the data
  always_ff @(posedge clock) begin
    if (reset) begin
      sb_out <= '0;
      p_out  <= '0;
      d_out  <= '0;
      a_out  <= '0;
    end else if (clken) begin
      sb_out <= sb_in;
      p_out  <= p_v;
      d_out  <= d_in;
      a_out  <= a_v;
    end
  end

endmodule

// File: rtl/div_pipelined.sv
// Fully pipelined non-restoring divider: magnitude conditioning stage, STAGES iteration
// stages, then a registered correction/sign-fixup stage. One operation per enabled cycle.
module div_pipelined
  import div_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clken,
  input  logic             in_valid,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [WIDTH-1:0] numer,
  input  logic [WIDTH-1:0] denom,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remain,
  output logic             div_by_zero
);

  localparam int unsigned RemW = div_rem_w(WIDTH);

  if (STAGES == 0 || WIDTH < 2 || WIDTH > DivMaxW || (WIDTH % STAGES) != 0 ||
      TAG_W < 1 || TAG_W > DivTagMaxW) begin : g_bad_params
    $error("div_pipelined: illegal WIDTH/STAGES/TAG_W combination");
  end

  localparam int unsigned Iters = WIDTH / STAGES;

  // Index 0 is the conditioning stage, index i the output of iteration stage i
  div_sb_t          sb_pipe [STAGES+1];
  logic [RemW-1:0]  p_pipe  [STAGES+1];
  logic [WIDTH-1:0] d_pipe  [STAGES+1];
  logic [WIDTH-1:0] a_pipe  [STAGES+1];

  logic             n_neg;
  logic             d_neg;
  logic             dbz;
  logic [WIDTH-1:0] n_mag;
  logic [WIDTH-1:0] d_mag;

  // Magnitudes and signs of the incoming operands
  always_comb begin
    n_neg = in_signed & numer[WIDTH-1];
    d_neg = in_signed & denom[WIDTH-1];
    n_mag = n_neg ? -numer : numer;
    d_mag = d_neg ? -denom : denom;
    dbz   = (denom == '0);
  end

  // Stage 0: capture magnitudes and sideband. For divide-by-zero the iterations yield an
  // all-ones quotient and |numer| as remainder, so suppressing the quotient negation and
  // restoring numer's sign returns numer unmodified.
  always_ff @(posedge clock) begin
    if (reset) begin
      sb_pipe[0] <= '0;
      p_pipe[0]  <= '0;
      d_pipe[0]  <= '0;
      a_pipe[0]  <= '0;
    end else if (clken) begin
      sb_pipe[0] <= '{valid:     in_valid,
                      is_signed: in_signed,
                      q_neg:     (n_neg ^ d_neg) & ~dbz,
                      r_neg:     n_neg,
                      dbz:       dbz,
                      tag:       DivTagMaxW'(in_tag)};
      p_pipe[0]  <= '0;
      d_pipe[0]  <= d_mag;
      a_pipe[0]  <= n_mag;
    end
  end

  for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
    div_nr_stage #(
      .WIDTH (WIDTH),
      .ITERS (Iters)
    ) u_stage (
      .clock  (clock),
      .reset  (reset),
      .clken  (clken),
      .sb_in  (sb_pipe[s]),
      .p_in   (p_pipe[s]),
      .d_in   (d_pipe[s]),
      .a_in   (a_pipe[s]),
      .sb_out (sb_pipe[s+1]),
      .p_out  (p_pipe[s+1]),
      .d_out  (d_pipe[s+1]),
      .a_out  (a_pipe[s+1])
    );
  end

  div_res_t res;
  logic     unused_final;

  // Remainder correction and sign restore for the slot leaving the last iteration stage
  always_comb begin
    res = div_fixup(div_rem_t'(signed'(p_pipe[STAGES])), div_word_t'(d_pipe[STAGES]),
                    div_word_t'(a_pipe[STAGES]), sb_pipe[STAGES].q_neg,
                    sb_pipe[STAGES].r_neg);
  end

  // Widened result bits and pass-through sideband fields not needed at the output
  assign unused_final = ^{res, sb_pipe[STAGES]};

  // Output register; data only loads for valid slots so bubbles leave results in place
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_tag     <= '0;
      quotient    <= '0;
      remain      <= '0;
      div_by_zero <= 1'b0;
    end else if (clken) begin
      out_valid <= sb_pipe[STAGES].valid;
      if (sb_pipe[STAGES].valid) begin
        out_tag     <= sb_pipe[STAGES].tag[TAG_W-1:0];
        quotient    <= res.quot[WIDTH-1:0];
        remain      <= res.rem[WIDTH-1:0];
        div_by_zero <= sb_pipe[STAGES].dbz;
      end
    end
  end

endmodule
